// File: rtl/computer_bus_pkg.sv
// ---------------------------------------------------------------------------
// computer_bus_pkg
//
// Purpose: shared definitions for the Computer's main-memory bus. Holds the
// memory arbiter state encoding and the default bus geometry constants that
// the arbiter, memory array and CPU bus interface all agree on.
//
// Contents:
//   DEF_NUM_REQ     - default number of memory requesters
//   DEF_ADDR_W      - default memory address width
//   DEF_DATA_W      - default memory data width
//   DEF_MEM_LATENCY - default cycles from mem_en to valid read data
//   arb_state_t     - arbiter FSM states
// ---------------------------------------------------------------------------
package computer_bus_pkg;

   localparam int DEF_NUM_REQ     = 3;
   localparam int DEF_ADDR_W      = 16;
   localparam int DEF_DATA_W      = 8;
   localparam int DEF_MEM_LATENCY = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

endpackage : computer_bus_pkg

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//
// Purpose: combinational round-robin picker. Scans the request vector
// starting at position ptr and wrapping modulo NUM_REQ, and reports the
// first set bit.
//
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  IDX_W    scan start position (must be < NUM_REQ)
//   valid out 1        at least one request is set
//   idx   out IDX_W    index of the selected request (0 when !valid)
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               valid,
   output logic [IDX_W-1:0]   idx
);

   // One extra bit so ptr + offset cannot overflow before the wrap.
   logic [IDX_W:0]   pos;
   logic [IDX_W-1:0] pos_idx;

   always_comb begin
      valid   = 1'b0;
      idx     = '0;
      pos     = '0;
      pos_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pos = {1'b0, ptr} + (IDX_W+1)'(i);
         if (pos >= (IDX_W+1)'(NUM_REQ)) begin
            pos = pos - (IDX_W+1)'(NUM_REQ);
         end
         pos_idx = pos[IDX_W-1:0];
         if (!valid && req[pos_idx]) begin
            valid = 1'b1;
            idx   = pos_idx;
         end
      end
   end

endmodule : rr_pick

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose: shares the single-port main memory between NUM_REQ requesters
// (CPU, debug loader, video). Round-robin arbitration, one transaction at a
// time, fixed-latency read pipeline, one-cycle ack to the winner.
//
// Ports:
//   clk       in   1               system clock, rising edge
//   rst_n     in   1               asynchronous active-low reset
//   req       in   NUM_REQ         per-requester request level
//   we        in   NUM_REQ         per-requester write enable
//   addr      in   NUM_REQ*ADDR_W  flattened per-requester addresses
//   wdata     in   NUM_REQ*DATA_W  flattened per-requester write data
//   gnt       out  NUM_REQ         one-hot grant, held for the transaction
//   ack       out  NUM_REQ         one-cycle completion pulse
//   rdata     out  DATA_W          last read data, valid in the ack cycle
//   busy      out  1               transaction in flight
//   mem_en    out  1               memory access strobe
//   mem_we    out  1               memory write enable (with mem_en)
//   mem_addr  out  ADDR_W          memory address
//   mem_wdata out  DATA_W          memory write data
//   mem_rdata in   DATA_W          memory read data, MEM_LATENCY after mem_en
//
// Every output is a flop whose next value is computed for the state being
// entered, so outputs line up exactly with the state they belong to.
// ---------------------------------------------------------------------------
module mem_arbiter
   import computer_bus_pkg::*;
#(
   parameter int NUM_REQ     = DEF_NUM_REQ,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        we,
   input  logic [NUM_REQ*ADDR_W-1:0] addr,
   input  logic [NUM_REQ*DATA_W-1:0] wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        ack,
   output logic [DATA_W-1:0]         rdata,
   output logic                      busy,
   output logic                      mem_en,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = 4;

   arb_state_t          state_q, state_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [IDX_W-1:0]    win_q, win_d;
   logic                txn_we_q, txn_we_d;
   logic [ADDR_W-1:0]   txn_addr_q, txn_addr_d;
   logic [DATA_W-1:0]   txn_wdata_q, txn_wdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                busy_q, busy_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

   logic                pick_valid;
   logic [IDX_W-1:0]    pick_idx;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req   (req),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      win_d       = win_q;
      txn_we_d    = txn_we_q;
      txn_addr_d  = txn_addr_q;
      txn_wdata_d = txn_wdata_q;
      cnt_d       = cnt_q;
      gnt_d       = gnt_q;
      ack_d       = '0;
      rdata_d     = rdata_q;
      busy_d      = busy_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;

      case (state_q)
         IDLE: begin
            gnt_d  = '0;
            busy_d = 1'b0;
            if (pick_valid) begin
               win_d       = pick_idx;
               txn_we_d    = we[pick_idx];
               txn_addr_d  = addr[pick_idx*ADDR_W +: ADDR_W];
               txn_wdata_d = wdata[pick_idx*DATA_W +: DATA_W];
               gnt_d       = NUM_REQ'(1) << pick_idx;
               busy_d      = 1'b1;
               // The memory strobe belongs to ISSUE, so it is loaded here.
               mem_en_d    = 1'b1;
               mem_we_d    = we[pick_idx];
               mem_addr_d  = addr[pick_idx*ADDR_W +: ADDR_W];
               mem_wdata_d = wdata[pick_idx*DATA_W +: DATA_W];
               state_d     = ISSUE;
            end
         end

         ISSUE: begin
            // WAIT lasts MEM_LATENCY cycles; its last cycle sees valid data.
            cnt_d   = CNT_W'(MEM_LATENCY - 1);
            state_d = WAIT;
         end

         WAIT: begin
            if (cnt_q == '0) begin
               if (!txn_we_q) begin
                  rdata_d = mem_rdata;
               end
               ack_d   = NUM_REQ'(1) << win_q;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         DONE: begin
            ptr_d   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
            gnt_d   = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         win_q       <= '0;
         txn_we_q    <= 1'b0;
         txn_addr_q  <= '0;
         txn_wdata_q <= '0;
         cnt_q       <= '0;
         gnt_q       <= '0;
         ack_q       <= '0;
         rdata_q     <= '0;
         busy_q      <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         win_q       <= win_d;
         txn_we_q    <= txn_we_d;
         txn_addr_q  <= txn_addr_d;
         txn_wdata_q <= txn_wdata_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         ack_q       <= ack_d;
         rdata_q     <= rdata_d;
         busy_q      <= busy_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign gnt       = gnt_q;
   assign ack       = ack_q;
   assign rdata     = rdata_q;
   assign busy      = busy_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Purpose: self-checking bench for mem_arbiter with a 2-cycle-latency memory
// model. Expected memory accesses and acks are queued by the stimulus and
// consumed by a negedge monitor as the arbiter presents them.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int NR = 3;
   localparam int AW = 16;
   localparam int DW = 8;
   localparam int ML = 2;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } mem_exp_t;

   typedef struct {
      int            idx;
      logic [DW-1:0] rdata;
   } ack_exp_t;

   logic              clk;
   logic              rst_n;
   logic [NR-1:0]     req;
   logic [NR-1:0]     we;
   logic [NR*AW-1:0]  addr;
   logic [NR*DW-1:0]  wdata;
   logic [NR-1:0]     gnt;
   logic [NR-1:0]     ack;
   logic [DW-1:0]     rdata;
   logic              busy;
   logic              mem_en;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_wdata;
   logic [DW-1:0]     mem_rdata;

   logic [DW-1:0]     mem_array [0:65535];
   logic [DW-1:0]     rd_s0;
   logic [DW-1:0]     rd_p1 = 8'h00;
   logic [DW-1:0]     rd_p2 = 8'h00;

   mem_exp_t          mem_q [$];
   ack_exp_t          ack_q [$];
   int                n_checks = 0;
   int                n_fail = 0;
   int                mem_en_count = 0;

   mem_arbiter #(
      .NUM_REQ     (NR),
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .MEM_LATENCY (ML)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .gnt       (gnt),
      .ack       (ack),
      .rdata     (rdata),
      .busy      (busy),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   // Memory model: the address is sampled mid-cycle while mem_en is high,
   // then two posedge stages make the data visible exactly ML cycles later.
   // Non-access cycles inject 0xEE so an early capture is visible.
   initial begin
      for (int a = 0; a < 65536; a++) begin
         mem_array[a] = pat(AW'(a));
      end
      mem_array[16'h1234] = 8'hA5;
      rd_s0 = 8'hEE;
      forever begin
         @(negedge clk);
         if (mem_en) begin
            rd_s0 = mem_array[mem_addr];
            if (mem_we) begin
               mem_array[mem_addr] = mem_wdata;
            end
         end else begin
            rd_s0 = 8'hEE;
         end
         @(posedge clk);
         rd_p1 <= rd_s0;
         rd_p2 <= rd_p1;
      end
   end

   assign mem_rdata = rd_p2;

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int idx, input logic w,
                                input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[idx]             = 1'b1;
      we[idx]              = w;
      addr[idx*AW +: AW]   = a;
      wdata[idx*DW +: DW]  = d;
   endtask

   task automatic expectTxn(input int idx, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW-1:0] rd);
      mem_exp_t m;
      ack_exp_t k;
      m.we = w;
      m.addr = a;
      m.wdata = d;
      k.idx = idx;
      k.rdata = rd;
      mem_q.push_back(m);
      ack_q.push_back(k);
   endtask

   task automatic monitorStep();
      mem_exp_t m;
      ack_exp_t k;
      if (rst_n) begin
         if (gnt != '0) begin
            checkOutput("gnt_onehot", 64'($onehot(gnt)), 64'd1);
         end
         if (mem_en) begin
            mem_en_count++;
            if (mem_q.size() == 0) begin
               checkOutput("unexpected_mem_en", 64'd1, 64'd0);
            end else begin
               m = mem_q.pop_front();
               checkOutput("mem_we", 64'(mem_we), 64'(m.we));
               checkOutput("mem_addr", 64'(mem_addr), 64'(m.addr));
               if (m.we) begin
                  checkOutput("mem_wdata", 64'(mem_wdata), 64'(m.wdata));
               end
            end
         end
         if (ack != '0) begin
            checkOutput("ack_with_gnt", 64'(ack & ~gnt), 64'd0);
            if (ack_q.size() == 0) begin
               checkOutput("unexpected_ack", 64'(ack), 64'd0);
            end else begin
               k = ack_q.pop_front();
               checkOutput("ack_order", 64'(ack), 64'(NR'(1) << k.idx));
               checkOutput("ack_rdata", 64'(rdata), 64'(k.rdata));
            end
         end
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_gnt"}, 64'(gnt), 64'd0);
      checkOutput({tag, "_ack"}, 64'(ack), 64'd0);
      checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
      checkOutput({tag, "_mem_en"}, 64'(mem_en), 64'd0);
      checkOutput({tag, "_mem_we"}, 64'(mem_we), 64'd0);
      checkOutput({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
      checkOutput({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
      checkOutput({tag, "_rdata"}, 64'(rdata), 64'd0);
   endtask

   task automatic runUntilAcks(input int want, input int budget, input string tag);
      int got;
      got = 0;
      for (int c = 0; c < budget && got < want; c++) begin
         step();
         if (ack != '0) begin
            got++;
            req = req & ~ack;
         end
      end
      checkOutput({tag, "_ack_count"}, 64'(got), 64'(want));
   endtask

   task automatic mainSequence();
      int mem_before;

      rst_n = 1'b1;
      req   = '0;
      we    = '0;
      addr  = '0;
      wdata = '0;
      #2 rst_n = 1'b0;
      #1;
      checkAllZero("reset");
      step();
      step();
      rst_n = 1'b1;
      step();

      // 1: single read from requester 0.
      applyStimulus(0, 1'b0, 16'h1234, 8'h00);
      expectTxn(0, 1'b0, 16'h1234, 8'h00, 8'hA5);
      step();
      checkOutput("t1_mem_en_c1", 64'(mem_en), 64'd1);
      checkOutput("t1_mem_addr_c1", 64'(mem_addr), 64'h1234);
      checkOutput("t1_mem_we_c1", 64'(mem_we), 64'd0);
      checkOutput("t1_gnt_c1", 64'(gnt), 64'b001);
      checkOutput("t1_busy_c1", 64'(busy), 64'd1);
      step();
      checkOutput("t1_mem_en_c2", 64'(mem_en), 64'd0);
      step();
      step();
      checkOutput("t1_ack_c4", 64'(ack), 64'b001);
      checkOutput("t1_rdata_c4", 64'(rdata), 64'hA5);
      req[0] = 1'b0;
      step();
      checkOutput("t1_busy_c5", 64'(busy), 64'd0);
      checkOutput("t1_gnt_c5", 64'(gnt), 64'd0);
      checkOutput("t1_ack_c5", 64'(ack), 64'd0);

      // 2: write from requester 1; rdata must keep 0xA5.
      applyStimulus(1, 1'b1, 16'h00FF, 8'h3C);
      expectTxn(1, 1'b1, 16'h00FF, 8'h3C, 8'hA5);
      mem_before = mem_en_count;
      runUntilAcks(1, 20, "t2");
      step();
      checkOutput("t2_mem_en_pulses", 64'(mem_en_count - mem_before), 64'd1);
      checkOutput("t2_mem_written", 64'(mem_array[16'h00FF]), 64'h3C);
      checkOutput("t2_rdata_kept", 64'(rdata), 64'hA5);
      we = '0;

      // 3: contention after reset, order 0,1,2.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      applyStimulus(0, 1'b0, 16'h0010, 8'h00);
      applyStimulus(1, 1'b0, 16'h0020, 8'h00);
      applyStimulus(2, 1'b0, 16'h0030, 8'h00);
      expectTxn(0, 1'b0, 16'h0010, 8'h00, 8'h4A);
      expectTxn(1, 1'b0, 16'h0020, 8'h00, 8'h7A);
      expectTxn(2, 1'b0, 16'h0030, 8'h00, 8'h6A);
      mem_before = mem_en_count;
      runUntilAcks(3, 40, "t3");
      step();
      step();
      checkOutput("t3_mem_en_pulses", 64'(mem_en_count - mem_before), 64'd3);

      // 4: fairness with 0 and 2 held continuously.
      applyStimulus(0, 1'b0, 16'h0100, 8'h00);
      applyStimulus(2, 1'b0, 16'h0200, 8'h00);
      expectTxn(0, 1'b0, 16'h0100, 8'h00, 8'h5B);
      expectTxn(2, 1'b0, 16'h0200, 8'h00, 8'h58);
      expectTxn(0, 1'b0, 16'h0100, 8'h00, 8'h5B);
      expectTxn(2, 1'b0, 16'h0200, 8'h00, 8'h58);
      begin
         int got;
         got = 0;
         for (int c = 0; c < 40 && got < 4; c++) begin
            step();
            if (ack != '0) begin
               got++;
               if (got == 4) begin
                  req = '0;
               end
            end
         end
         checkOutput("t4_ack_count", 64'(got), 64'd4);
      end
      step();

      // 5: reset during WAIT of a read; no ack may follow.
      applyStimulus(1, 1'b0, 16'h0300, 8'h00);
      begin
         mem_exp_t m;
         m.we = 1'b0;
         m.addr = 16'h0300;
         m.wdata = 8'h00;
         mem_q.push_back(m);
      end
      step();
      step();
      checkOutput("t5_in_wait_busy", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      checkAllZero("t5_async");
      req = '0;
      step();
      step();
      checkOutput("t5_no_ack", 64'(ack), 64'd0);
      rst_n = 1'b1;
      step();
      applyStimulus(2, 1'b0, 16'h0400, 8'h00);
      expectTxn(2, 1'b0, 16'h0400, 8'h00, 8'h5E);
      step();
      checkOutput("t5_mem_en_c1", 64'(mem_en), 64'd1);
      checkOutput("t5_gnt_c1", 64'(gnt), 64'b100);
      step();
      step();
      step();
      checkOutput("t5_ack_c4", 64'(ack), 64'b100);
      req = '0;
      step();

      // 6: requester 1 drops req in cycle 2 of a read.
      applyStimulus(1, 1'b0, 16'h0500, 8'h00);
      expectTxn(1, 1'b0, 16'h0500, 8'h00, 8'h5F);
      step();
      step();
      req[1] = 1'b0;
      step();
      step();
      checkOutput("t6_ack_c4", 64'(ack), 64'b010);
      checkOutput("t6_rdata_c4", 64'(rdata), 64'h5F);
      step();
      checkOutput("t6_busy_c5", 64'(busy), 64'd0);
      step();
      step();

      checkOutput("pending_mem", 64'(mem_q.size()), 64'd0);
      checkOutput("pending_ack", 64'(ack_q.size()), 64'd0);
   endtask

   initial begin
      fork
         begin
            forever begin
               @(negedge clk);
               monitorStep();
            end
         end
         begin
            #100000;
            $display("[TB] FAIL watchdog: got timeout, expected completion");
            $fatal(1, "[TB] watchdog expired");
         end
         mainSequence();
      join_any
      disable fork;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mem_arbiter
